// File: rtl/cmos_frame_crop_if.sv
// Pixel-stream bundle between the CMOS packer, the crop stage and the LCD FIFO.
// The slave side is the crop block; the master side is the packer/FIFO environment.
interface cmos_frame_crop_if;
    logic        vsync_i;
    logic        href_i;
    logic        de_i;
    logic [15:0] pdata_i;
    logic [15:0] pdata_o;
    logic        de_o;
    logic        frame_start_o;
    logic        busy_o;
    logic        line_err_o;

    modport slave (
        input  vsync_i, href_i, de_i, pdata_i,
        output pdata_o, de_o, frame_start_o, busy_o, line_err_o
    );

    modport master (
        output vsync_i, href_i, de_i, pdata_i,
        input  pdata_o, de_o, frame_start_o, busy_o, line_err_o
    );
endinterface

// File: rtl/cmos_frame_crop.sv
// Drops the first SKIP_FRAMES sensor frames, then forwards a CROP_W x CROP_H window per frame.
// Optional line-length check is enabled with macro CMOS_CROP_LINE_CHECK_EN.
module cmos_frame_crop #(
    parameter int SRC_W       = 640,
    parameter int SRC_H       = 480,
    parameter int X_START     = 80,
    parameter int Y_START     = 104,
    parameter int CROP_W      = 480,
    parameter int CROP_H      = 272,
    parameter int SKIP_FRAMES = 10,
    parameter bit VS_POL      = 1'b1
) (
    input logic              pclk,
    input logic              rst,
    cmos_frame_crop_if.slave bus
);
    localparam int CW = $clog2(SRC_W + 1);
    localparam int RW = $clog2(SRC_H + 1);
    localparam logic [CW-1:0] COL_MAX = CW'(SRC_W);
    localparam logic [CW-1:0] X_LO    = CW'(X_START);
    localparam logic [CW-1:0] X_HI    = CW'(X_START + CROP_W);
    localparam logic [RW-1:0] ROW_MAX = RW'(SRC_H);
    localparam logic [RW-1:0] Y_LO    = RW'(Y_START);
    localparam logic [RW-1:0] Y_HI    = RW'(Y_START + CROP_H);
    localparam logic [RW-1:0] Y_LAST  = RW'(Y_START + CROP_H - 1);
    localparam logic [7:0]    SKIP_N  = 8'(SKIP_FRAMES);

    typedef enum logic [1:0] {SKIP, SYNC, ACTIVE, DONE} state_t;
    localparam state_t RST_ST = (SKIP_FRAMES == 0) ? SYNC : SKIP;

    state_t          state, state_nxt;
    logic            vs_q, vs_d, hs_q, hs_d;
    logic [CW-1:0]   col;
    logic [RW-1:0]   row;
    logic [7:0]      skip_cnt;
    logic            frame_edge, line_end, pix, in_win;
    logic            fwd, fs_nxt, busy;
    logic            de_r, fs_r, err_r;
    logic [15:0]     pd_r;

    always_ff @(posedge pclk or posedge rst) begin
        if (rst) begin
            vs_q <= 1'b0;
            vs_d <= 1'b0;
            hs_q <= 1'b0;
            hs_d <= 1'b0;
        end else begin
            vs_q <= bus.vsync_i;
            vs_d <= vs_q;
            hs_q <= bus.href_i;
            hs_d <= hs_q;
        end
    end

    assign frame_edge = (vs_q == VS_POL) && (vs_d != VS_POL);
    assign line_end   = hs_d && !hs_q;
    // Strobes outside a line are not pixels at all.
    assign pix        = bus.de_i && hs_q;

    always_ff @(posedge pclk or posedge rst) begin
        if (rst) begin
            col      <= '0;
            row      <= '0;
            skip_cnt <= '0;
        end else begin
            if (frame_edge || line_end) col <= '0;
            else if (pix && col != COL_MAX) col <= col + 1'b1;
            if (frame_edge) row <= '0;
            else if (line_end && row != ROW_MAX) row <= row + 1'b1;
            if (state == SKIP && frame_edge) skip_cnt <= skip_cnt + 8'd1;
        end
    end

    always_ff @(posedge pclk or posedge rst) begin
        if (rst) state <= RST_ST;
        else     state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        case (state)
            SKIP:   if (frame_edge && (skip_cnt + 8'd1) == SKIP_N) state_nxt = SYNC;
            SYNC:   if (frame_edge) state_nxt = ACTIVE;
            ACTIVE: if (frame_edge) state_nxt = ACTIVE;
                    else if (line_end && row == Y_LAST) state_nxt = DONE;
            DONE:   if (frame_edge) state_nxt = ACTIVE;
            default: state_nxt = RST_ST;
        endcase
    end

    always_comb begin
        in_win = (col >= X_LO) && (col < X_HI) && (row >= Y_LO) && (row < Y_HI);
        fwd    = (state == ACTIVE) && pix && !frame_edge && in_win;
        fs_nxt = frame_edge && (state != SKIP);
        busy   = (state == ACTIVE);
    end

    always_ff @(posedge pclk or posedge rst) begin
        if (rst) begin
            de_r <= 1'b0;
            fs_r <= 1'b0;
            pd_r <= '0;
        end else begin
            de_r <= fwd;
            fs_r <= fs_nxt;
            if (fwd) pd_r <= bus.pdata_i;
        end
    end

`ifdef CMOS_CROP_LINE_CHECK_EN
    // Saturation at SRC_W means over-long lines are not flagged, only short ones.
    always_ff @(posedge pclk or posedge rst) begin
        if (rst) err_r <= 1'b0;
        else if (state == ACTIVE && line_end && col != COL_MAX) err_r <= 1'b1;
    end
`else
    assign err_r = 1'b0;
`endif

    assign bus.pdata_o       = pd_r;
    assign bus.de_o          = de_r;
    assign bus.frame_start_o = fs_r;
    assign bus.busy_o        = busy;
    assign bus.line_err_o    = err_r;
endmodule

// File: doc/cmos_frame_crop.md
Name: cmos_frame_crop

Overview:
- Sits between the CMOS 8-to-16-bit packer and the LCD FIFO/timing stage, in the camera pixel-clock domain.
- Takes packed RGB565 pixels plus raw href/vsync and discards the sensor's first SKIP_FRAMES frames while the sensor settles.
- Crops a CROP_W x CROP_H window from each frame and forwards only the window pixels, with a frame-start pulse for the FIFO.

Parameters:
- SRC_W, 640, active 16-bit pixels per sensor line.
- SRC_H, 480, active lines per sensor frame.
- X_START, 80, first forwarded column (0-based).
- Y_START, 104, first forwarded line (0-based).
- CROP_W, 480, forwarded pixels per line.
- CROP_H, 272, forwarded lines per frame.
- SKIP_FRAMES, 10, whole frames dropped after reset; range 0..255.
- VS_POL, 1, vsync_i active level (1 = active-high).

Ports:
- pclk, input, 1, camera pixel clock; all logic on rising edge.
- rst, input, 1, asynchronous active-high reset.
- vsync_i, input, 1, raw sensor vsync.
- href_i, input, 1, raw sensor href (line valid).
- de_i, input, 1, one-cycle strobe per packed 16-bit pixel.
- pdata_i, input, 16, packed pixel, valid when de_i=1.
- pdata_o, output, 16, cropped pixel.
- de_o, output, 1, cropped pixel strobe.
- frame_start_o, output, 1, one-cycle pulse before the first pixel of each forwarded frame.
- busy_o, output, 1, high while a frame is being forwarded.
- line_err_o, output, 1, sticky line-length error flag (see Optional Feature).

Behaviour:
- Reset: all outputs 0; col=0, row=0, skip_cnt=0; state=SKIP (or SYNC if SKIP_FRAMES=0).
- vsync_i and href_i are registered once. Frame edge = registered vsync transitions to the VS_POL level. Line end = registered href falling edge.
- col counter increments on every de_i; it saturates at SRC_W and clears on line end. row counter increments on line end; it saturates at SRC_H and clears on frame edge.
- Window condition: X_START <= col < X_START+CROP_W and Y_START <= row < Y_START+CROP_H, evaluated on the pre-increment col/row of the de_i cycle.
- Forwarding: pdata_o/de_o registered with exactly 1-cycle latency from de_i. pdata_o holds its last value when de_o=0.
- State machine:
  - SKIP: on each frame edge, skip_cnt++; when skip_cnt reaches SKIP_FRAMES → SYNC.
  - SYNC: wait for a frame edge → ACTIVE. In the same cycle: frame_start_o=1, busy_o=1, counters cleared.
  - ACTIVE: forward window pixels. After the line end that makes row = Y_START+CROP_H → DONE, busy_o=0.
  - DONE: drop all pixels. Frame edge → ACTIVE, with a frame_start_o pulse.
  - ACTIVE + frame edge (short or truncated frame): restart ACTIVE, pulse frame_start_o again, clear counters. No pixel is emitted in the frame-edge cycle.
- A frame edge arriving with de_i in the same cycle: edge wins, that pixel is dropped.
- de_i with href low is ignored (counted nowhere).
- Reset asserted mid-frame: outputs drop to 0 immediately. After release, SKIP_FRAMES frames are skipped again.
- No backpressure: downstream must accept every de_o strobe.

Optional Feature:
- Macro CMOS_CROP_LINE_CHECK_EN.
- Defined: on each line end while in ACTIVE, if col != SRC_W, line_err_o is set to 1. It stays set until reset. The check never affects forwarding.
- Not defined: line_err_o is tied 0 and the compare logic is absent.

Test Plan:
All scenarios use SRC_W=16, SRC_H=8, X_START=2, Y_START=1, CROP_W=4, CROP_H=3, SKIP_FRAMES=1, VS_POL=1, de_i every other cycle, pixel value = row*16+col.
1. Reset release, send 2 frames → frame 0 produces no de_o and no frame_start_o. Frame 1: one frame_start_o, then exactly 12 de_o with values 0x12..0x15, 0x22..0x25, 0x32..0x35. Each de_o is 1 cycle after its de_i.
2. SKIP_FRAMES=0, single frame → frame_start_o on the first vsync edge; 12 pixels as above; busy_o falls after line 3 ends. Lines 4..7 produce nothing.
3. Truncated frame: vsync edge after line 2 of an active frame → 8 pixels (0x12..0x25), a new frame_start_o, then the next frame forwards 12 pixels from 0x12.
4. de_i coincident with the vsync edge → that pixel is not output; frame_start_o=1; no de_o in that cycle.
5. Assert rst during line 2 of a forwarded frame → de_o, busy_o and frame_start_o go 0 asynchronously. After release, the next frame is skipped and the following one is forwarded fully.
6. With CMOS_CROP_LINE_CHECK_EN defined: shorten line 2 to 15 pixels → line_err_o=1 from the cycle after that line end and stays 1. Without the macro, line_err_o stays 0 and pixel output is identical.
